// File: rtl/if_id_stall_ctrl.sv
// if_id_stall_ctrl: owns PC and IF/ID, freezes them on load-use stalls, injects ID/EX bubbles, applies branch redirects.
// Define HAZ_STATS_EN to build the saturating stall_cnt/flush_cnt statistics counters.
module if_id_stall_ctrl #(
   parameter logic [31:0] PC_RESET      = 32'h0000_0000,
   parameter int          PC_STEP       = 4,
   parameter int          BUBBLE_CYCLES = 1,
   parameter int          CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [31:0]      branch_target,
   input  logic [31:0]      imem_ins,
   output logic [31:0]      pc,
   output logic [31:0]      if_id_ins,
   output logic [31:0]      if_id_pc,
   output logic             id_ex_bubble
`ifdef HAZ_STATS_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);
   localparam logic RUN  = 1'b0;
   localparam logic HOLD = 1'b1;
   logic       state;
   logic       next_state;
   logic [2:0] hold_cnt;
   logic       enter;
   logic       advance;
   logic       keep_hold;
   always_comb begin
      enter      = (state == RUN) && stall && !branch_taken;
      keep_hold  = (state == HOLD) && (hold_cnt != 3'd0) && !branch_taken;
      advance    = !branch_taken && !enter && !keep_hold;
      next_state = (enter || keep_hold) ? HOLD : RUN;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         hold_cnt     <= 3'd0;
         pc           <= PC_RESET;
         if_id_ins    <= 32'd0;
         if_id_pc     <= 32'd0;
         id_ex_bubble <= 1'b0;
      end else begin
         state        <= next_state;
         id_ex_bubble <= (next_state == HOLD);
         hold_cnt     <= enter ? 3'(BUBBLE_CYCLES - 1) : keep_hold ? hold_cnt - 3'd1 : 3'd0;
         if (branch_taken) begin
            pc        <= branch_target;
            if_id_ins <= 32'd0;
            if_id_pc  <= 32'd0;
         end else if (advance) begin
            pc        <= pc + 32'(PC_STEP);
            if_id_ins <= imem_ins;
            if_id_pc  <= pc;
         end
      end
   end
`ifdef HAZ_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (state == HOLD && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
         if (branch_taken && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// tb_if_id_stall_ctrl: two instances (1 and 3 bubbles per stall) checked every cycle against a behavioural model,
// plus directed literal checks; HAZ_STATS_EN also checks the statistics counters.
module tb_if_id_stall_ctrl;
   logic clk = 1'b0;
   logic rst, stall, br;
   logic [31:0] tgt;
   logic [31:0] pc_a, ins_a, ipc_a, pc_b, ins_b, ipc_b;
   logic bub_a, bub_b;
   logic [3:0] sc_a, fc_a, sc_b, fc_b;
   int checks = 0;
   int errors = 0;
   logic live = 1'b0;
   int bub_n [2] = '{1, 3};
   logic [31:0] m_pc [2];
   logic [31:0] m_ins [2];
   logic [31:0] m_ipc [2];
   logic m_hold [2];
   int m_left [2];
   int m_sc [2];
   int m_fc [2];

   always #5 clk = ~clk;

   if_id_stall_ctrl #(.PC_RESET(32'h0), .PC_STEP(4), .BUBBLE_CYCLES(1), .CNT_W(4)) ua (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(br), .branch_target(tgt), .imem_ins(~pc_a),
      .pc(pc_a), .if_id_ins(ins_a), .if_id_pc(ipc_a), .id_ex_bubble(bub_a)
`ifdef HAZ_STATS_EN
      , .stall_cnt(sc_a), .flush_cnt(fc_a)
`endif
   );
   if_id_stall_ctrl #(.PC_RESET(32'h0), .PC_STEP(4), .BUBBLE_CYCLES(3), .CNT_W(4)) ub (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(br), .branch_target(tgt), .imem_ins(~pc_b),
      .pc(pc_b), .if_id_ins(ins_b), .if_id_pc(ipc_b), .id_ex_bubble(bub_b)
`ifdef HAZ_STATS_EN
      , .stall_cnt(sc_b), .flush_cnt(fc_b)
`endif
   );
`ifndef HAZ_STATS_EN
   assign {sc_a, fc_a, sc_b, fc_b} = '0;
`endif

   // m_left = HOLD cycles still to come including the current one
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_pc[i] <= 32'h0; m_ins[i] <= 32'h0; m_ipc[i] <= 32'h0;
            m_hold[i] <= 1'b0; m_left[i] <= 0; m_sc[i] <= 0; m_fc[i] <= 0;
         end else begin
            if (m_hold[i]) m_sc[i] <= (m_sc[i] < 15) ? m_sc[i] + 1 : 15;
            if (br) begin
               m_fc[i] <= (m_fc[i] < 15) ? m_fc[i] + 1 : 15;
               m_pc[i] <= tgt; m_ins[i] <= 32'h0; m_ipc[i] <= 32'h0; m_hold[i] <= 1'b0;
            end else if (!m_hold[i] && stall) begin
               m_hold[i] <= 1'b1; m_left[i] <= bub_n[i];
            end else if (m_hold[i] && m_left[i] > 1) begin
               m_left[i] <= m_left[i] - 1;
            end else begin
               m_hold[i] <= 1'b0;
               m_pc[i] <= m_pc[i] + 32'd4; m_ins[i] <= ~m_pc[i]; m_ipc[i] <= m_pc[i];
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (live) begin
         chk("a.pc", pc_a, m_pc[0]); chk("a.ins", ins_a, m_ins[0]);
         chk("a.ipc", ipc_a, m_ipc[0]); chk("a.bub", 32'(bub_a), 32'(m_hold[0]));
         chk("b.pc", pc_b, m_pc[1]); chk("b.ins", ins_b, m_ins[1]);
         chk("b.ipc", ipc_b, m_ipc[1]); chk("b.bub", 32'(bub_b), 32'(m_hold[1]));
`ifdef HAZ_STATS_EN
         chk("a.sc", 32'(sc_a), 32'(m_sc[0])); chk("a.fc", 32'(fc_a), 32'(m_fc[0]));
         chk("b.sc", 32'(sc_b), 32'(m_sc[1])); chk("b.fc", 32'(fc_b), 32'(m_fc[1]));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [4:0] pat_a, pat_b;
      rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'h0;
      step(); live = 1'b1; step();
      chk("t1.pc", pc_a, 32'h0); chk("t1.ins", ins_a, 32'h0); chk("t1.bub", 32'(bub_a), 32'h0);
      rst = 1'b0;
      step(); chk("t1.pc4", pc_a, 32'h4);
      step(); chk("t1.pc8", pc_b, 32'h8); chk("t1.ipc", ipc_a, 32'h4); chk("t1.ins4", ins_a, 32'hFFFF_FFFB);
      step(); step(); chk("t2.pc10", pc_a, 32'h10);
      stall = 1'b1; step();
      chk("t2.hold_pc", pc_a, 32'h10); chk("t2.bub", 32'(bub_a), 32'h1); chk("t2.ipc", ipc_a, 32'hC);
      stall = 1'b0; step();
      chk("t2.pc14", pc_a, 32'h14); chk("t2.bub0", 32'(bub_a), 32'h0); chk("t2.b_bub", 32'(bub_b), 32'h1);
      repeat (4) step();
      stall = 1'b1;
      for (int k = 4; k >= 0; k--) begin
         step(); pat_a[k] = bub_a; pat_b[k] = bub_b;
      end
      chk("t3.pat_b", 32'(pat_b), 32'b11101); chk("t3.pat_a", 32'(pat_a), 32'b10101);
      stall = 1'b0; repeat (4) step();
      stall = 1'b1; step();
      chk("t4.hold", 32'(bub_b), 32'h1);
      stall = 1'b0; br = 1'b1; tgt = 32'h200; step();
      chk("t4.pc", pc_b, 32'h200); chk("t4.ins", ins_b, 32'h0); chk("t4.bub", 32'(bub_b), 32'h0);
      chk("t4.ipc", ipc_a, 32'h0);
      br = 1'b0; step();
      chk("t4.pc204", pc_b, 32'h204); chk("t4.ipc200", ipc_b, 32'h200);
      br = 1'b1; tgt = 32'hFFFF_FFFC; step(); chk("t5.pcfc", pc_a, 32'hFFFF_FFFC);
      br = 1'b0; step(); chk("t5.wrap", pc_a, 32'h0); chk("t5.wipc", ipc_a, 32'hFFFF_FFFC);
      stall = 1'b1; step(); chk("t5.hold", 32'(bub_b), 32'h1);
      stall = 1'b0; rst = 1'b1; step();
      chk("t5.rst_pc", pc_b, 32'h0); chk("t5.rst_bub", 32'(bub_b), 32'h0);
      rst = 1'b0; stall = 1'b1; repeat (40) step();
      stall = 1'b0; repeat (4) step();
`ifdef HAZ_STATS_EN
      chk("t6.sc_a", 32'(sc_a), 32'hF); chk("t6.sc_b", 32'(sc_b), 32'hF);
`endif
      br = 1'b1; tgt = 32'h40; step(); br = 1'b0; step();
      br = 1'b1; tgt = 32'h80; step(); br = 1'b0; step();
      chk("t6.pc", pc_a, 32'h84);
`ifdef HAZ_STATS_EN
      chk("t6.fc_a", 32'(fc_a), 32'h2); chk("t6.fc_b", 32'(fc_b), 32'h2);
`endif
      live = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
